// File: rtl/sr_latch_driver.sv
// Purpose : drives an external SR latch (s/r/en) from set/reset/toggle/hold commands,
//           with dead time before each pulse and a feedback check after it.
// Latency : accept at edge k -> GAP k+1..k+GAP, PULSE up to k+GAP+PULSE, CHECK next, ready at k+GAP+PULSE+2.
// Backpr. : cmd_ready high only in IDLE; commands presented while busy are ignored (no queuing).
// Ports   : clk, rst (sync, active-high); cmd_valid/cmd/cmd_ready command handshake;
//           q_fb latch feedback; s/r/en latch drive; q_model expected latch state;
//           done one-cycle strobe in CHECK; mismatch sticky feedback error flag.
module sr_latch_driver #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       en,
    output logic       q_model,
    output logic       done,
    output logic       mismatch
);

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_SET    = 2'b01;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        PULSE = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          act_set;   // latched action: 1 = set pulse, 0 = reset pulse
    logic          accept;
    logic          next_act;

    assign accept = cmd_valid && cmd_ready && (cmd != CMD_HOLD);

    // Toggle is resolved against the model at accept time, so a toggle
    // always produces the opposite of the state we believe the latch holds.
    assign next_act = (cmd == CMD_SET) || ((cmd == CMD_TOGGLE) && !q_model);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            act_set   <= 1'b0;
            q_model   <= 1'b0;
            mismatch  <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            en        <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // hold commands are consumed here without leaving IDLE
                    if (accept) begin
                        act_set   <= next_act;
                        cnt       <= CW'(GAP_CYCLES - 1);
                        en        <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        cnt   <= CW'(PULSE_CYCLES - 1);
                        s     <= act_set;
                        r     <= !act_set;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        s       <= 1'b0;
                        r       <= 1'b0;
                        q_model <= act_set;
                        done    <= 1'b1;
                        state   <= CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CHECK: begin
                    // q_model already reflects the pulse just issued
                    if (q_fb != q_model) begin
                        mismatch <= 1'b1;
                    end
                    en        <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    s         <= 1'b0;
                    r         <= 1'b0;
                    en        <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Purpose : checks sr_latch_driver (default params and PULSE=1/GAP=3) against a
//           timeline model built from the command timing rules, with emulated latches.
// Latency : one step per clock; outputs compared at the falling edge.
// Backpr. : model accepts only when idle, mirroring the cmd_ready contract.
module tb_sr_latch_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       force0;

    logic cmd_ready1, s1, r1, en1, q_model1, done1, mismatch1, q_fb1;
    logic cmd_ready2, s2, r2, en2, q_model2, done2, mismatch2, q_fb2;
    logic latch1 = 1'b0;
    logic latch2 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state per instance: t = cycles since accept (0 = idle)
    int t   [2];
    bit act [2];
    bit qm  [2];
    bit mm  [2];
    int gp  [2] = '{1, 3};
    int pp  [2] = '{2, 1};

    always #5 clk = ~clk;

    assign q_fb1 = force0 ? 1'b0 : latch1;
    assign q_fb2 = force0 ? 1'b0 : latch2;

    sr_latch_driver dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready1),
        .q_fb(q_fb1), .s(s1), .r(r1), .en(en1), .q_model(q_model1), .done(done1),
        .mismatch(mismatch1)
    );

    sr_latch_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready2),
        .q_fb(q_fb2), .s(s2), .r(r2), .en(en2), .q_model(q_model2), .done(done2),
        .mismatch(mismatch2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic qf;
        for (int i = 0; i < 2; i++) begin
            qf = (i == 0) ? q_fb1 : q_fb2;
            if (rst) begin
                t[i] = 0; qm[i] = 0; mm[i] = 0; act[i] = 0;
            end else if (t[i] == 0) begin
                if (cmd_valid && cmd != 2'b00) begin
                    act[i] = (cmd == 2'b01) ? 1'b1 : (cmd == 2'b10) ? 1'b0 : !qm[i];
                    t[i]   = 1;
                end
            end else if (t[i] < gp[i] + pp[i]) begin
                t[i]++;
            end else if (t[i] == gp[i] + pp[i]) begin
                qm[i] = act[i];
                t[i]++;
            end else begin
                if (qf != qm[i]) mm[i] = 1;
                t[i] = 0;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic vs, input logic vr,
                              input logic ven, input logic vq, input logic vd, input logic vm);
        bit in_pulse;
        string p;
        p = (i == 0) ? "d1" : "d2";
        in_pulse = (t[i] > gp[i]) && (t[i] <= gp[i] + pp[i]);
        chk({p, "_cmd_ready"}, rdy, t[i] == 0);
        chk({p, "_en"},        ven, t[i] != 0);
        chk({p, "_s"},         vs,  in_pulse && act[i]);
        chk({p, "_r"},         vr,  in_pulse && !act[i]);
        chk({p, "_done"},      vd,  t[i] == gp[i] + pp[i] + 1);
        chk({p, "_q_model"},   vq,  qm[i]);
        chk({p, "_mismatch"},  vm,  mm[i]);
        chk({p, "_s_and_r"},   vs && vr, 1'b0);
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input logic rv, input logic v, input logic [1:0] c);
        rst = rv; cmd_valid = v; cmd = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_inst(0, cmd_ready1, s1, r1, en1, q_model1, done1, mismatch1);
        check_inst(1, cmd_ready2, s2, r2, en2, q_model2, done2, mismatch2);
        // ideal latch: follows s/r while enabled
        if (en1 && s1) latch1 = 1'b1; else if (en1 && r1) latch1 = 1'b0;
        if (en2 && s2) latch2 = 1'b1; else if (en2 && r2) latch2 = 1'b0;
    endtask

    task automatic busy(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'($urandom), 2'($urandom));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; force0 = 1'b0;
        for (int i = 0; i < 2; i++) begin t[i] = 0; act[i] = 0; qm[i] = 0; mm[i] = 0; end

        // reset with random inputs
        step(1'b1, 1'($urandom), 2'($urandom));
        step(1'b1, 1'($urandom), 2'($urandom));

        // set then reset
        step(1'b0, 1'b1, 2'b01); busy(4);
        step(1'b0, 1'b1, 2'b10); busy(4);

        // three toggles from q_model=0
        for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 2'b11); busy(4); end
        chk("toggle_final_q", q_model1, 1'b1);

        // hold commands: nothing happens
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b00);

        // feedback stuck low during a set
        force0 = 1'b1;
        step(1'b0, 1'b1, 2'b01); busy(4);
        step(1'b0, 1'b0, 2'b00);
        chk("mismatch_set", mismatch1, 1'b1);
        force0 = 1'b0;
        step(1'b0, 1'b1, 2'b10); busy(4);
        chk("mismatch_sticky", mismatch1, 1'b1);
        step(1'b1, 1'b0, 2'b00);
        chk("mismatch_cleared", mismatch1, 1'b0);

        // abort during PULSE (dut1 is in its first pulse cycle)
        step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 2'b00);
        chk("pulse_s_before_abort", s1, 1'b1);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);

        // held valid set is re-accepted back-to-back
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 2'b01);

        // random traffic with occasional reset and feedback faults
        for (int k = 0; k < 400; k++) begin
            force0 = ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 40) == 0), 1'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
